regfile_alu_sequencer: RTL and testbench

Multi-cycle controller that executes register-to-register commands `rd = rs1 OP rs2` on the team's RegisterFile and ALU.
- Accepts one command at a time over a valid/ready handshake and reads both source registers.
- Runs the ALU, writes the result back, then returns it on a valid/ready response port.
- Sits between the command source (testbench or future decode stage) and the `*_regfile` / `*_alu` ports of the datapath top.

---
 rtl/regfile_alu_sequencer_pkg.sv | 19 +
 rtl/regfile_alu_sequencer_if.sv | 29 ++
 rtl/regfile_alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_alu_sequencer_pkg.sv
// Shared types for the register-file/ALU command sequencer: FSM states and ALU opcodes.
package regfile_alu_seq_pkg;

  localparam int ALU_OP_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } seq_state_e;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// Command and response handshake bundle between a command source and the sequencer.
interface regfile_alu_sequencer_if
  import regfile_alu_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ALU_OP_W-1:0]   cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_rd;
  logic [ADDR_WIDTH-1:0] cmd_rs1;
  logic [ADDR_WIDTH-1:0] cmd_rs2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/regfile_alu_sequencer.sv
// Multi-cycle controller running rd = rs1 OP rs2 on an external register file and ALU,
// one command at a time: READ -> EXEC -> WRITE -> RESP.
module regfile_alu_sequencer
  import regfile_alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter bit R0_READONLY = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  regfile_alu_sequencer_if.slave bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  retired_count,
  output logic [ADDR_WIDTH-1:0] A1_regfile,
  output logic [ADDR_WIDTH-1:0] A2_regfile,
  output logic [ADDR_WIDTH-1:0] A3_regfile,
  output logic                  WE3_regfile,
  output logic [DATA_WIDTH-1:0] WD3_regfile,
  input  logic [DATA_WIDTH-1:0] RD1_regfile,
  input  logic [DATA_WIDTH-1:0] RD2_regfile,
  output logic [ALU_OP_W-1:0]   opcode_alu,
  output logic [DATA_WIDTH-1:0] inputA_alu,
  output logic [DATA_WIDTH-1:0] inputB_alu,
  input  logic [DATA_WIDTH-1:0] result_alu
);

  seq_state_e            state_q, state_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  cmd_ready_s, rsp_valid_s, busy_s, we3_s, wr_blocked_s;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = READ; else state_d = IDLE;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE; else state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: command latch, operand/result capture, retire counter
  always_comb begin
    op_d  = op_q;
    rd_d  = rd_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          rd_d  = bus.cmd_rd;
          rs1_d = bus.cmd_rs1;
          rs2_d = bus.cmd_rs2;
        end else begin
          op_d = op_q;
        end
      end
      READ: begin
        opa_d = RD1_regfile;
        opb_d = RD2_regfile;
      end
      EXEC:  res_d = result_alu;
      WRITE: res_d = res_q;
      RESP: begin
        if (bus.rsp_ready) cnt_d = cnt_q + CNT_WIDTH'(1);
        else               cnt_d = cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_q  <= {ALU_OP_W{1'b0}};
      rd_q  <= {ADDR_WIDTH{1'b0}};
      rs1_q <= {ADDR_WIDTH{1'b0}};
      rs2_q <= {ADDR_WIDTH{1'b0}};
      opa_q <= {DATA_WIDTH{1'b0}};
      opb_q <= {DATA_WIDTH{1'b0}};
      res_q <= {DATA_WIDTH{1'b0}};
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      op_q  <= op_d;
      rd_q  <= rd_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  // State-decoded outputs; ready and write enable drop while reset is held
  always_comb begin
    wr_blocked_s = R0_READONLY && (rd_q == {ADDR_WIDTH{1'b0}});
    cmd_ready_s  = 1'b0;
    rsp_valid_s  = 1'b0;
    busy_s       = 1'b1;
    we3_s        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_s = RST_N;
        busy_s      = 1'b0;
      end
      WRITE:   we3_s       = RST_N && !wr_blocked_s;
      RESP:    rsp_valid_s = 1'b1;
      default: busy_s      = 1'b1;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = res_q;
  assign busy          = busy_s;
  assign retired_count = cnt_q;
  assign A1_regfile    = rs1_q;
  assign A2_regfile    = rs2_q;
  assign A3_regfile    = rd_q;
  assign WE3_regfile   = we3_s;
  assign WD3_regfile   = res_q;
  assign opcode_alu    = op_q;
  assign inputA_alu    = opa_q;
  assign inputB_alu    = opb_q;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench: sequencer plus behavioural register file and ALU, 2-bit retire counter.
module tb_regfile_alu_sequencer;
  import regfile_alu_seq_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          CLK;
  logic          RST_N;
  logic          busy;
  logic [CW-1:0] retired_count;
  logic [AW-1:0] A1_regfile, A2_regfile, A3_regfile;
  logic          WE3_regfile;
  logic [DW-1:0] WD3_regfile, RD1_regfile, RD2_regfile;
  logic [1:0]    opcode_alu;
  logic [DW-1:0] inputA_alu, inputB_alu, result_alu;

  regfile_alu_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_alu_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .R0_READONLY(1'b1), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave),
    .busy(busy), .retired_count(retired_count),
    .A1_regfile(A1_regfile), .A2_regfile(A2_regfile), .A3_regfile(A3_regfile),
    .WE3_regfile(WE3_regfile), .WD3_regfile(WD3_regfile),
    .RD1_regfile(RD1_regfile), .RD2_regfile(RD2_regfile),
    .opcode_alu(opcode_alu), .inputA_alu(inputA_alu), .inputB_alu(inputB_alu),
    .result_alu(result_alu)
  );

  // r8/r9 hold the seed constants that r1/r2 get loaded from
  logic [DW-1:0] rf [32] = '{8: 32'd5, 9: 32'd7, default: 32'd0};
  int n_vec = 0, n_err = 0, cyc = 0, we3_pulses = 0, exp_cnt = 0;

  function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input logic [DW-1:0] a, b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  assign RD1_regfile = rf[A1_regfile];
  assign RD2_regfile = rf[A2_regfile];
  assign result_alu  = alu_ref(opcode_alu, inputA_alu, inputB_alu);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (WE3_regfile) begin
      rf[A3_regfile] <= WD3_regfile;
      we3_pulses     <= we3_pulses + 1;
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command, wait (bounded) for cmd_ready, return in READ with the accept cycle
  task automatic issue(input logic [1:0] op, input logic [4:0] rd, rs1, rs2, output int acc);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op  = op;
    bus.cmd_rd  = rd;
    bus.cmd_rs1 = rs1;
    bus.cmd_rs2 = rs2;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check_value("accept_in_time", 32'(guard < 20), 32'd1);
    tick();
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [DW-1:0] exp, input int hold, output int acc);
    issue(op, rd, rs1, rs2, acc);
    check_value("read_busy", 32'(busy), 32'd1);
    check_value("read_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_value("read_a1", 32'(A1_regfile), 32'(rs1));
    check_value("read_a2", 32'(A2_regfile), 32'(rs2));
    check_value("read_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_value("exec_opcode", 32'(opcode_alu), 32'(op));
    check_value("exec_we3", 32'(WE3_regfile), 32'd0);
    tick();
    check_value("write_we3", 32'(WE3_regfile), 32'(rd != 5'd0));
    check_value("write_a3", 32'(A3_regfile), 32'(rd));
    check_value("write_wd3", WD3_regfile, exp);
    tick();
    check_value("resp_valid", 32'(bus.rsp_valid), 32'd1);
    check_value("resp_data", bus.rsp_data, exp);
    check_value("resp_we3", 32'(WE3_regfile), 32'd0);
    if (hold > 0) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_rd    = 5'd31;
      for (int i = 0; i < hold; i++) begin
        tick();
        check_value("hold_valid", 32'(bus.rsp_valid), 32'd1);
        check_value("hold_data", bus.rsp_data, exp);
        check_value("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_value("hold_busy", 32'(busy), 32'd1);
        check_value("hold_count", 32'(retired_count), 32'(exp_cnt));
        check_value("hold_rd_kept", 32'(A3_regfile), 32'(rd));
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    tick();
    exp_cnt = (exp_cnt + 1) % 4;
    check_value("done_count", 32'(retired_count), 32'(exp_cnt));
    check_value("done_busy", 32'(busy), 32'd0);
    check_value("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("done_rf", rf[rd], (rd == 5'd0) ? 32'd0 : exp);
  endtask

  int acc1, acc2, pulses_before;
  int wrap_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    RST_N = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op  = 2'd0;
    bus.cmd_rd  = 5'd0;
    bus.cmd_rs1 = 5'd0;
    bus.cmd_rs2 = 5'd0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check_value("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("rst_count", 32'(retired_count), 32'd0);
    check_value("rst_a1", 32'(A1_regfile), 32'd0);
    check_value("rst_wd3", WD3_regfile, 32'd0);
    check_value("rst_we3", 32'(WE3_regfile), 32'd0);
    RST_N = 1'b1;
    #1;
    check_value("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    run_cmd(ALU_ADD, 5'd1, 5'd8, 5'd0, 32'd5, 0, acc1);
    run_cmd(ALU_ADD, 5'd2, 5'd9, 5'd0, 32'd7, 0, acc1);
    run_cmd(ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd12, 0, acc1);

    pulses_before = we3_pulses;
    run_cmd(ALU_ADD, 5'd0, 5'd1, 5'd2, 32'd12, 0, acc1);
    check_value("r0_no_pulse", 32'(we3_pulses), 32'(pulses_before));

    run_cmd(ALU_ADD, 5'd4, 5'd1, 5'd2, 32'd12, 0, acc1);
    run_cmd(ALU_ADD, 5'd5, 5'd4, 5'd1, 32'd17, 0, acc2);
    check_value("b2b_spacing", 32'(acc2 - acc1), 32'd5);

    run_cmd(ALU_SUB, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFFE, 0, acc1);
    run_cmd(ALU_AND, 5'd10, 5'd1, 5'd2, 32'd5, 0, acc1);
    run_cmd(ALU_OR, 5'd11, 5'd3, 5'd1, 32'd13, 0, acc1);

    run_cmd(ALU_ADD, 5'd12, 5'd2, 5'd2, 32'd14, 10, acc1);

    // Abort ADD r6 while it is in WRITE
    issue(ALU_ADD, 5'd6, 5'd1, 5'd2, acc1);
    tick();
    tick();
    check_value("abort_we3_before", 32'(WE3_regfile), 32'd1);
    pulses_before = we3_pulses;
    RST_N = 1'b0;
    #1;
    check_value("abort_we3_gated", 32'(WE3_regfile), 32'd0);
    check_value("abort_ready_gated", 32'(bus.cmd_ready), 32'd0);
    tick();
    exp_cnt = 0;
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("abort_a3", 32'(A3_regfile), 32'd0);
    check_value("abort_wd3", WD3_regfile, 32'd0);
    check_value("abort_inputa", inputA_alu, 32'd0);
    check_value("abort_opcode", 32'(opcode_alu), 32'd0);
    check_value("abort_count", 32'(retired_count), 32'd0);
    RST_N = 1'b1;
    tick();
    check_value("abort_r6", rf[6], 32'd0);
    check_value("abort_no_pulse", 32'(we3_pulses), 32'(pulses_before));

    for (int i = 0; i < 5; i++) begin
      run_cmd(ALU_ADD, 5'(13 + i), 5'd1, 5'd0, 32'd5, 0, acc1);
      check_value("wrap_seq", 32'(retired_count), 32'(wrap_seq[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
